// File: rtl/sb_incr_initiator.sv
// sb_incr_initiator
// Switchboard traffic initiator and checker for the byte-increment loopback
// responder. Sends NPKT patterned packets on TX, checks that every RX response
// carries each byte incremented by one (mod 256), in order, and reports
// pass/fail with counters.
// Build option: define SB_INIT_TERM_EN to send one all-ones terminator packet
// after the last response, before entering DONE.
module sb_incr_initiator #(
  parameter int unsigned DW      = 256,
  parameter int unsigned NPKT    = 16,
  parameter int unsigned MAX_OUT = 4,
  parameter logic [7:0]  SEED    = 8'h00,
  parameter logic [31:0] DEST    = 32'h0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          go,
  output logic [DW-1:0] tx_data,
  output logic [31:0]   tx_dest,
  output logic          tx_last,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic [31:0]   rx_dest,
  input  logic          rx_last,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   sent_count,
  output logic [15:0]   recv_count,
  output logic [15:0]   err_count
);

  localparam int unsigned   NB        = DW / 8;
  localparam int unsigned   CW        = 16;
  localparam logic [CW-1:0] NPKT_C    = CW'(NPKT);
  localparam logic [CW-1:0] LAST_C    = CW'(NPKT - 1);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
`ifdef SB_INIT_TERM_EN
    S_TERM = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_n;

  logic          tx_fire;
  logic          rx_fire;
  logic          rsp_bad;

  logic [CW-1:0] sent_n;
  logic [CW-1:0] recv_n;
  logic [CW-1:0] err_n;
  logic          tx_valid_n;
  logic [DW-1:0] tx_data_n;
  logic [31:0]   tx_dest_n;
  logic          tx_last_n;
  logic          rx_ready_n;
  logic          busy_n;
  logic          done_n;
  logic          pass_n;

  // Packet pattern: byte i = SEED + n + i + ofs, all 8-bit wrapping.
  function automatic logic [DW-1:0] pattern(input logic [CW-1:0] n, input logic [7:0] ofs);
    logic [DW-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      p[i*8 +: 8] = SEED + n[7:0] + 8'(i) + ofs;
    end
    return p;
  endfunction

  // Saturating error increment.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : CW'(v + CW'(1));
  endfunction

  assign tx_fire = tx_valid && tx_ready;
  assign rx_fire = rx_valid && rx_ready;
  assign rsp_bad = (rx_data != pattern(recv_count, 8'd1)) || (rx_dest != DEST) || !rx_last;

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic; run ends when the last expected response is accepted.
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: if (go) state_n = S_RUN;
      S_RUN: begin
        if (rx_fire && (recv_count != sent_count) && (recv_count == LAST_C)) begin
`ifdef SB_INIT_TERM_EN
          state_n = S_TERM;
`else
          state_n = S_DONE;
`endif
        end
      end
`ifdef SB_INIT_TERM_EN
      S_TERM: if (tx_fire) state_n = S_DONE;
`endif
      S_DONE: if (go) state_n = S_RUN;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of counters and registered outputs.
  always_comb begin
    sent_n     = sent_count;
    recv_n     = recv_count;
    err_n      = err_count;
    tx_valid_n = tx_valid;
    tx_data_n  = tx_data;
    tx_dest_n  = tx_dest;
    tx_last_n  = tx_last;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          sent_n = '0;
          recv_n = '0;
          err_n  = '0;
        end
      end
      S_RUN: begin
        if (tx_fire) sent_n = CW'(sent_count + CW'(1));
        if (rx_fire) begin
          if (recv_count == sent_count) begin
            err_n = sat_inc(err_count);
          end else begin
            recv_n = CW'(recv_count + CW'(1));
            if (rsp_bad) err_n = sat_inc(err_count);
          end
        end
      end
      default: ;
    endcase

    // A pending TX packet is held; otherwise the send window is re-evaluated.
    if (state_n == S_RUN) begin
      if (!tx_valid || tx_ready) begin
        tx_valid_n = (sent_n < NPKT_C) && (CW'(sent_n - recv_n) < MAX_OUT_C);
        tx_data_n  = tx_valid_n ? pattern(sent_n, 8'd0) : '0;
        tx_dest_n  = tx_valid_n ? DEST : 32'h0;
        tx_last_n  = tx_valid_n;
      end
`ifdef SB_INIT_TERM_EN
    end else if (state_n == S_TERM) begin
      tx_valid_n = 1'b1;
      tx_data_n  = '1;
      tx_dest_n  = DEST;
      tx_last_n  = 1'b1;
`endif
    end else begin
      tx_valid_n = 1'b0;
      tx_data_n  = '0;
      tx_dest_n  = 32'h0;
      tx_last_n  = 1'b0;
    end

    rx_ready_n = (state_n == S_RUN);
    busy_n     = (state_n != S_IDLE) && (state_n != S_DONE);
    done_n     = (state_n == S_DONE);
    pass_n     = done_n && (err_n == '0);
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      tx_dest    <= 32'h0;
      tx_last    <= 1'b0;
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      sent_count <= '0;
      recv_count <= '0;
      err_count  <= '0;
    end else begin
      tx_valid   <= tx_valid_n;
      tx_data    <= tx_data_n;
      tx_dest    <= tx_dest_n;
      tx_last    <= tx_last_n;
      rx_ready   <= rx_ready_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      sent_count <= sent_n;
      recv_count <= recv_n;
      err_count  <= err_n;
    end
  end

endmodule

// File: tb/tb_sb_incr_initiator.sv
// Bench for sb_incr_initiator: behavioural responder plus a spec-level model
// of counters, status and the TX send window, compared every cycle.
`timescale 1ns/1ps
module tb_sb_incr_initiator;

  localparam int          DW      = 64;
  localparam int          NB      = DW / 8;
  localparam int          NPKT    = 12;
  localparam int          MAX_OUT = 2;
  localparam logic [7:0]  SEED    = 8'hFD;
  localparam logic [31:0] DEST    = 32'hA5A5_0003;
`ifdef SB_INIT_TERM_EN
  localparam int          TERM_PKTS = 1;
`else
  localparam int          TERM_PKTS = 0;
`endif

  logic          clk = 1'b0;
  logic          nreset;
  logic          go;
  logic [DW-1:0] tx_data;
  logic [31:0]   tx_dest;
  logic          tx_last;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic [31:0]   rx_dest;
  logic          rx_last;
  logic          rx_valid;
  logic          rx_ready;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   sent_count;
  logic [15:0]   recv_count;
  logic [15:0]   err_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: 0 idle, 1 run, 2 terminator, 3 done.
  int            m_st   = 0;
  int            m_sent = 0;
  int            m_recv = 0;
  int            m_err  = 0;
  bit            m_pend = 1'b0;
  logic [DW-1:0] m_pend_data = '0;
  bit            c_go = 1'b0, c_tx = 1'b0, c_rx = 1'b0, c_bad = 1'b0;
  int            go_cyc = 0, term_pkts = 0, max_os = 0;
  int            tx_cyc_q[$];

  // Responder state.
  logic [DW-1:0] rq_data[$];
  int            rq_rel[$];
  int            pkt_pushed = 0, corrupt_idx = -1, dmin = 0, dmax = 0;
  bit            rdy_rand = 1'b0;

  always #5 clk = ~clk;

  sb_incr_initiator #(
    .DW(DW), .NPKT(NPKT), .MAX_OUT(MAX_OUT), .SEED(SEED), .DEST(DEST)
  ) u_dut (
    .clk(clk), .nreset(nreset), .go(go),
    .tx_data(tx_data), .tx_dest(tx_dest), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_dest(rx_dest), .rx_last(rx_last),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .done(done), .pass(pass),
    .sent_count(sent_count), .recv_count(recv_count), .err_count(err_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Packet n byte i = (SEED + n + i + add) mod 256.
  function automatic logic [DW-1:0] m_pat(input int n, input int add);
    logic [DW-1:0] p;
    for (int i = 0; i < NB; i++) p[i*8 +: 8] = 8'((int'(SEED) + n + i + add) % 256);
    return p;
  endfunction

  // Model update on each active edge from handshakes captured before it.
  always @(posedge clk) begin
    cyc++;
    if (nreset) begin
      case (m_st)
        0, 3: if (c_go) begin
          m_st = 1; m_sent = 0; m_recv = 0; m_err = 0; go_cyc = cyc;
        end
        1: begin
          if (c_rx) begin
            if (m_recv == m_sent) m_err++;
            else begin
              if (c_bad) m_err++;
              m_recv++;
            end
          end
          if (c_tx) m_sent++;
          if (m_sent - m_recv > max_os) max_os = m_sent - m_recv;
          if (m_recv == NPKT) m_st = (TERM_PKTS != 0) ? 2 : 3;
        end
        2: if (c_tx) m_st = 3;
        default: ;
      endcase
    end
  end

  // Compare DUT against model every cycle, then capture this cycle's handshakes.
  always @(negedge clk) begin
    logic [DW-1:0] r;
    if (!nreset) begin
      m_st = 0; m_sent = 0; m_recv = 0; m_err = 0; m_pend = 1'b0;
      chk("rst_tx_data", 64'(tx_data), 64'd0);
      chk("rst_tx_dest", 64'(tx_dest), 64'd0);
      chk("rst_tx_last", 64'(tx_last), 64'd0);
    end
    chk("busy", 64'(busy), 64'(m_st == 1 || m_st == 2));
    chk("done", 64'(done), 64'(m_st == 3));
    chk("pass", 64'(pass), 64'(m_st == 3 && m_err == 0));
    chk("rx_ready", 64'(rx_ready), 64'(m_st == 1));
    chk("sent_count", 64'(sent_count), 64'(m_sent));
    chk("recv_count", 64'(recv_count), 64'(m_recv));
    chk("err_count", 64'(err_count), 64'(m_err));
    if (m_st == 1) begin
      if (m_pend) begin
        chk("tx_hold_valid", 64'(tx_valid), 64'd1);
        chk("tx_hold_data", 64'(tx_data), 64'(m_pend_data));
      end else begin
        chk("tx_valid_window", 64'(tx_valid), 64'(m_sent < NPKT && (m_sent - m_recv) < MAX_OUT));
      end
    end else if (m_st == 2) begin
      chk("term_valid", 64'(tx_valid), 64'd1);
      chk("term_data", 64'(tx_data), {64{1'b1}});
    end else begin
      chk("tx_valid_off", 64'(tx_valid), 64'd0);
    end
    if (tx_valid) begin
      chk("tx_last", 64'(tx_last), 64'd1);
      chk("tx_dest", 64'(tx_dest), 64'(DEST));
    end

    c_go  = go;
    c_tx  = tx_valid && tx_ready;
    c_rx  = rx_valid && rx_ready;
    c_bad = (rx_data != m_pat(m_recv, 1)) || (rx_dest != DEST) || !rx_last;
    if (c_tx && m_st == 1) begin
      chk("tx_pkt_data", 64'(tx_data), 64'(m_pat(m_sent, 0)));
      tx_cyc_q.push_back(cyc + 1);
      for (int i = 0; i < NB; i++) r[i*8 +: 8] = tx_data[i*8 +: 8] + 8'd1;
      if (pkt_pushed == corrupt_idx) r[47:40] = r[47:40] ^ 8'h5A;
      pkt_pushed++;
      rq_data.push_back(r);
      rq_rel.push_back(cyc + 1 + int'($urandom_range(dmin, dmax)));
    end
    if (c_tx && m_st == 2) term_pkts++;
    m_pend      = tx_valid && !tx_ready;
    m_pend_data = tx_data;
  end

  // One clock; inputs change only here, just after the active edge.
  task automatic tick();
    int rel;
    @(posedge clk);
    #1;
    if (rx_valid && c_rx) rx_valid = 1'b0;
    if (!rx_valid && rq_data.size() > 0 && cyc >= rq_rel[0]) begin
      rx_data  = rq_data.pop_front();
      rel      = rq_rel.pop_front();
      rx_dest  = DEST;
      rx_last  = 1'b1;
      rx_valid = 1'b1;
    end
    tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic start_run();
    tx_cyc_q.delete();
    term_pkts  = 0;
    max_os     = 0;
    pkt_pushed = 0;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (m_st != 3 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (m_st != 3) begin
      failures++;
      $display("FAIL %s_timeout act=state%0d exp=done", nm, m_st);
    end
    @(negedge clk);
    chk({nm, "_term_pkts"}, 64'(term_pkts), 64'(TERM_PKTS));
    chk({nm, "_sent"}, 64'(sent_count), 64'(NPKT));
    chk({nm, "_recv"}, 64'(recv_count), 64'(NPKT));
    chk({nm, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] p;
    nreset = 1'b1; go = 1'b0; tx_ready = 1'b0;
    rx_valid = 1'b0; rx_data = '0; rx_dest = '0; rx_last = 1'b0;
    #2 nreset = 1'b0;

    // Pin the model's pattern arithmetic by hand.
    p = m_pat(0, 0);
    chk("pin_p0_b0", 64'(p[7:0]), 64'hFD);
    chk("pin_p0_b3", 64'(p[31:24]), 64'h00);
    p = m_pat(257, 1);
    chk("pin_p257_rsp_b0", 64'(p[7:0]), 64'hFF);
    chk("pin_p257_rsp_b1", 64'(p[15:8]), 64'h00);

    repeat (3) tick();
    nreset = 1'b1;
    tick();

    // Full-rate run: packet n is sent n+1 cycles after go.
    rdy_rand = 1'b0; dmin = 0; dmax = 0;
    start_run();
    wait_done("run_a");
    chk("run_a_pass", 64'(pass), 64'd1);
    chk("run_a_max_os", 64'(max_os), 64'd1);
    for (int n = 0; n < NPKT; n++) chk("run_a_latency", 64'(tx_cyc_q[n] - go_cyc), 64'(n + 1));

    // Random backpressure and response delay; a go while busy is ignored.
    rdy_rand = 1'b1; dmin = 0; dmax = 3;
    start_run();
    repeat (5) tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_done("run_b");
    chk("run_b_pass", 64'(pass), 64'd1);

    // Corrupted byte 5 of packet 2.
    rdy_rand = 1'b0; dmin = 0; dmax = 1; corrupt_idx = 2;
    start_run();
    wait_done("run_c");
    corrupt_idx = -1;
    chk("run_c_err", 64'(err_count), 64'd1);
    chk("run_c_pass", 64'(pass), 64'd0);

    // Slow responder: the send window must fill and stall at MAX_OUT.
    dmin = 10; dmax = 10;
    start_run();
    wait_done("run_d");
    chk("run_d_max_os", 64'(max_os), 64'(MAX_OUT));
    chk("run_d_pass", 64'(pass), 64'd1);

    // Unexpected response before any packet is sent.
    tick();
    dmin = 0; dmax = 2;
    start_run();
    tx_ready = 1'b0;
    rx_data  = {$urandom, $urandom};
    rx_dest  = DEST;
    rx_last  = 1'b1;
    rx_valid = 1'b1;
    tick();
    @(negedge clk);
    chk("inject_err", 64'(err_count), 64'd1);
    chk("inject_recv", 64'(recv_count), 64'd0);
    wait_done("run_e");
    chk("run_e_err", 64'(err_count), 64'd1);
    chk("run_e_pass", 64'(pass), 64'd0);

    // Reset in the middle of a run, then a clean run afterwards.
    tick();
    rdy_rand = 1'b0; dmin = 0; dmax = 0;
    start_run();
    for (int k = 0; k < 100 && m_sent < 2; k++) tick();
    nreset = 1'b0;
    rq_data.delete();
    rq_rel.delete();
    rx_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_sent", 64'(sent_count), 64'd0);
    tick();
    tick();
    nreset = 1'b1;
    tick();
    rdy_rand = 1'b1; dmin = 0; dmax = 4;
    start_run();
    wait_done("run_f");
    chk("run_f_pass", 64'(pass), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
